// File: rtl/fifo_burst_scheduler.sv
// fifo_burst_scheduler
//   Read-side sequencer for the 32-bit DMA staging FIFO. It watches the FIFO
//   fill level and launches a DMA burst either when a full burst is available
//   or when a partial burst has waited TIMEOUT_CYC idle cycles. It then
//   handshakes with the DMA engine and drains exactly the granted word count
//   through a 2-entry output buffer with ready/valid backpressure.
//
// Parameters
//   BURST_WORDS  words per full burst (1..65535)
//   TIMEOUT_CYC  idle cycles with a non-empty FIFO before a partial flush (>=1)
//
// Ports
//   clk              in   system clock (FIFO read side and DMA engine)
//   rst_n            in   asynchronous active-low reset
//   enable           in   allow new bursts; only looked at while idle
//   fifo_rd_count    in   FIFO read-side word count (28 bits)
//   fifo_next_valid  in   FIFO non-empty and out of reset
//   fifo_dout        in   FIFO read data (32 bits)
//   fifo_dout_valid  in   fifo_dout valid, one cycle after fifo_rd_en
//   fifo_rd_en       out  FIFO read strobe
//   dma_req          out  burst request to the DMA engine
//   dma_len          out  burst length in words, stable while dma_req is high
//   dma_gnt          in   one-cycle grant pulse
//   dma_data         out  burst data (32 bits)
//   dma_data_vld     out  dma_data valid
//   dma_ready        in   DMA engine accepts dma_data this cycle
//   dma_done         out  one-cycle pulse after the last word is accepted
//   busy             out  high whenever the sequencer is not idle
//   burst_cnt        out  completed bursts, wrapping (32 bits)
module fifo_burst_scheduler #(
  parameter int BURST_WORDS = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [27:0] fifo_rd_count,
  input  logic        fifo_next_valid,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_dout_valid,
  output logic        fifo_rd_en,
  output logic        dma_req,
  output logic [15:0] dma_len,
  input  logic        dma_gnt,
  output logic [31:0] dma_data,
  output logic        dma_data_vld,
  input  logic        dma_ready,
  output logic        dma_done,
  output logic        busy,
  output logic [31:0] burst_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [27:0]   BURST28   = 28'(BURST_WORDS);
  localparam logic [15:0]   BURST16   = 16'(BURST_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t        state, next_state;
  logic [15:0]   len, next_len;
  logic [TW-1:0] timer;
  logic [15:0]   issued;
  logic [15:0]   sent;
  logic [15:0]   sent_next;
  logic          inflight;

  logic [31:0]   buf_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    buf_occ;
  logic          buf_push;
  logic          buf_pop;
  logic [2:0]    used;

  assign buf_push  = inflight && fifo_dout_valid;
  assign buf_pop   = dma_data_vld && dma_ready;
  assign sent_next = sent + {15'd0, buf_pop};

  // Words already claimed on the buffer: those sitting in it plus the one
  // whose FIFO read is still in flight. A word leaving this cycle frees its
  // slot immediately, which is what lets a steady dma_ready stream one word
  // per cycle while the buffer still can never hold more than two entries.
  assign used       = {1'b0, buf_occ} + {2'b00, inflight};
  assign fifo_rd_en = (state == S_XFER) && (issued < len) && fifo_next_valid
                      && (used < (buf_pop ? 3'd3 : 3'd2));

  assign dma_req      = (state == S_REQ);
  assign dma_len      = dma_req ? len : 16'd0;
  assign dma_done     = (state == S_DONE);
  assign busy         = (state != S_IDLE);
  assign dma_data_vld = (buf_occ != 2'd0);
  assign dma_data     = dma_data_vld ? buf_mem[rd_ptr] : 32'd0;

  // Next-state and burst length selection. A full burst wins over a timeout
  // flush; the flush length is the current count, which is below BURST_WORDS
  // whenever that branch is reached, so the low 16 bits hold all of it.
  always_comb begin
    next_state = state;
    next_len   = len;
    case (state)
      S_IDLE: begin
        if (enable && (fifo_rd_count >= BURST28)) begin
          next_state = S_REQ;
          next_len   = BURST16;
        end else if (enable && (fifo_rd_count != 28'd0) && (timer == TIMER_MAX)) begin
          next_state = S_REQ;
          next_len   = fifo_rd_count[15:0];
        end
      end
      S_REQ: begin
        if (dma_gnt) begin
          next_state = S_XFER;
        end
      end
      S_XFER: begin
        if (sent_next == len) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State, idle timer, burst counters and the read-in-flight flag. The timer
  // only runs while staying idle with data waiting and is parked at zero
  // everywhere else, so each idle period starts its timeout from scratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= 16'd0;
      timer     <= '0;
      issued    <= 16'd0;
      sent      <= 16'd0;
      inflight  <= 1'b0;
      burst_cnt <= 32'd0;
    end else begin
      state    <= next_state;
      len      <= next_len;
      inflight <= fifo_rd_en;

      if ((state == S_IDLE) && (next_state == S_IDLE)) begin
        if (fifo_rd_count == 28'd0) begin
          timer <= '0;
        end else if (timer != TIMER_MAX) begin
          timer <= timer + TIMER_ONE;
        end
      end else begin
        timer <= '0;
      end

      if ((state == S_REQ) && dma_gnt) begin
        issued <= 16'd0;
        sent   <= 16'd0;
      end else begin
        if (fifo_rd_en) begin
          issued <= issued + 16'd1;
        end
        sent <= sent_next;
      end

      if (state == S_DONE) begin
        burst_cnt <= burst_cnt + 32'd1;
      end
    end
  end

  // Output buffer bookkeeping. A push and a pop in the same cycle leave the
  // occupancy unchanged; a reset drops whatever words were held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      buf_occ <= 2'd0;
    end else begin
      if (buf_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (buf_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({buf_push, buf_pop})
        2'b10:   buf_occ <= buf_occ + 2'd1;
        2'b01:   buf_occ <= buf_occ - 2'd1;
        default: buf_occ <= buf_occ;
      endcase
    end
  end

  // Buffer storage needs no reset: dma_data is masked whenever it is empty.
  always_ff @(posedge clk) begin
    if (buf_push) begin
      buf_mem[wr_ptr] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// tb_fifo_burst_scheduler
//   Randomized bench for fifo_burst_scheduler. The FIFO is modelled as a
//   queue of random words. Each burst's expected data is a snapshot of the
//   queue head taken when the request appears. Expected lengths and request
//   latencies come from the burst/timeout rules.
module tb_fifo_burst_scheduler;

  localparam int BURST = 256;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [27:0] fifo_rd_count = '0;
  logic        fifo_next_valid = 1'b0;
  logic [31:0] fifo_dout = '0;
  logic        fifo_dout_valid = 1'b0;
  logic        fifo_rd_en;
  logic        dma_req;
  logic [15:0] dma_len;
  logic        dma_gnt = 1'b0;
  logic [31:0] dma_data;
  logic        dma_data_vld;
  logic        dma_ready = 1'b0;
  logic        dma_done;
  logic        busy;
  logic [31:0] burst_cnt;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int viol = 0;
  int outstanding = 0;
  int acc_n = 0;
  int first_acc = 0;
  int last_acc = 0;
  int exp_bursts = 0;

  logic [31:0] q[$];
  logic [31:0] got[$];
  logic [31:0] exp_words[$];

  fifo_burst_scheduler #(
    .BURST_WORDS(BURST),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo_rd_count(fifo_rd_count),
    .fifo_next_valid(fifo_next_valid),
    .fifo_dout(fifo_dout),
    .fifo_dout_valid(fifo_dout_valid),
    .fifo_rd_en(fifo_rd_en),
    .dma_req(dma_req),
    .dma_len(dma_len),
    .dma_gnt(dma_gnt),
    .dma_data(dma_data),
    .dma_data_vld(dma_data_vld),
    .dma_ready(dma_ready),
    .dma_done(dma_done),
    .busy(busy),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  function automatic void update_count();
    fifo_rd_count   = 28'(q.size());
    fifo_next_valid = (q.size() != 0);
  endfunction

  function automatic void push_words(input int n);
    for (int i = 0; i < n; i++) q.push_back($urandom);
    update_count();
  endfunction

  function automatic void snapshot(input int n);
    exp_words.delete();
    for (int i = 0; i < n && i < q.size(); i++) exp_words.push_back(q[i]);
  endfunction

  function automatic int count_mismatch();
    int m = 0;
    for (int i = 0; i < exp_words.size(); i++)
      if (i >= got.size() || got[i] !== exp_words[i]) m++;
    if (got.size() > exp_words.size()) m += got.size() - exp_words.size();
    return m;
  endfunction

  function automatic void clear_stats();
    got.delete();
    rd_pulses   = 0;
    done_pulses = 0;
    viol        = 0;
    acc_n       = 0;
  endfunction

  // One clock: observe outputs on the falling edge, then play the FIFO's part
  // just after the rising edge (read data one cycle after the strobe, random
  // stray valid pulses otherwise).
  task automatic tick();
    bit rd_s;
    bit acc;
    @(negedge clk);
    rd_s = (fifo_rd_en === 1'b1);
    acc  = (dma_data_vld === 1'b1) && (dma_ready === 1'b1);
    if (acc) begin
      got.push_back(dma_data);
      if (acc_n == 0) first_acc = cyc;
      last_acc = cyc;
      acc_n++;
    end
    if (rd_s) rd_pulses++;
    if (dma_done === 1'b1) done_pulses++;
    outstanding = outstanding - (acc ? 1 : 0) + (rd_s ? 1 : 0);
    if (outstanding > 2) viol++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s && q.size() != 0) begin
      fifo_dout       = q.pop_front();
      fifo_dout_valid = 1'b1;
    end else begin
      fifo_dout       = $urandom;
      fifo_dout_valid = ($urandom_range(0, 3) == 0);
    end
    update_count();
  endtask

  task automatic wait_req(input int max_cyc, output int n, output bit seen);
    n    = 0;
    seen = (dma_req === 1'b1);
    while (!seen && n < max_cyc) begin
      tick();
      n++;
      seen = (dma_req === 1'b1);
    end
  endtask

  task automatic grant();
    dma_gnt = 1'b1;
    tick();
    dma_gnt = 1'b0;
  endtask

  // mode 0: always ready, 1: ready 1010..., other: random ready.
  task automatic drain(input int mode, input int max_cyc, output bit ok);
    int k = 0;
    while (done_pulses == 0 && k < max_cyc) begin
      case (mode)
        0:       dma_ready = 1'b1;
        1:       dma_ready = ((k % 2) == 0);
        default: dma_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      k++;
    end
    ok = (done_pulses != 0);
    dma_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    #3;
    checks++;
    if ({dma_req, fifo_rd_en, dma_data_vld, dma_done, busy} !== 5'b0) begin
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000", {dma_req, fifo_rd_en, dma_data_vld, dma_done, busy});
    end else passed++;
    checks++;
    if (dma_len !== 16'd0) $display("[TB] FAIL reset_len: got %0d, expected 0", dma_len);
    else passed++;
    checks++;
    if (dma_data !== 32'd0) $display("[TB] FAIL reset_data: got %0h, expected 0", dma_data);
    else passed++;
    checks++;
    if (burst_cnt !== 32'd0) $display("[TB] FAIL reset_burst_cnt: got %0d, expected 0", burst_cnt);
    else passed++;
    repeat (2) tick();
    rst_n  = 1'b1;
    enable = 1'b1;
    outstanding = 0;
  endtask

  task automatic test_full_burst();
    int n;
    bit seen;
    bit ok;
    clear_stats();
    push_words(BURST);
    wait_req(8, n, seen);
    checks++;
    if (!seen || n != 1) $display("[TB] FAIL full_req_latency: got %0d (seen %0d), expected 1", n, seen);
    else passed++;
    checks++;
    if (dma_len !== 16'(BURST)) $display("[TB] FAIL full_len: got %0d, expected %0d", dma_len, BURST);
    else passed++;
    snapshot(BURST);
    grant();
    drain(0, 4 * BURST, ok);
    exp_bursts++;
    checks++;
    if (got.size() != BURST || count_mismatch() != 0)
      $display("[TB] FAIL full_data: got %0d words with %0d wrong, expected %0d words", got.size(), count_mismatch(), BURST);
    else passed++;
    checks++;
    if (last_acc - first_acc != BURST - 1)
      $display("[TB] FAIL full_streaming: got span %0d cycles, expected %0d", last_acc - first_acc, BURST - 1);
    else passed++;
    checks++;
    if (!ok || done_pulses != 1) $display("[TB] FAIL full_done_pulse: got %0d pulses, expected 1", done_pulses);
    else passed++;
    checks++;
    if (burst_cnt !== 32'(exp_bursts) || busy !== 1'b0)
      $display("[TB] FAIL full_burst_cnt: got %0d busy %0d, expected %0d busy 0", burst_cnt, busy, exp_bursts);
    else passed++;
    checks++;
    if (rd_pulses != BURST) $display("[TB] FAIL full_rd_pulses: got %0d, expected %0d", rd_pulses, BURST);
    else passed++;
  endtask

  // The timer needs TMO counting edges to reach its limit, plus the edge that
  // moves to the request state.
  task automatic test_timeout();
    int n;
    bit seen;
    bit ok;
    clear_stats();
    push_words(10);
    wait_req(TMO + 8, n, seen);
    checks++;
    if (!seen || n != TMO + 1) $display("[TB] FAIL timeout_latency: got %0d (seen %0d), expected %0d", n, seen, TMO + 1);
    else passed++;
    checks++;
    if (dma_len !== 16'd10) $display("[TB] FAIL timeout_len: got %0d, expected 10", dma_len);
    else passed++;
    snapshot(10);
    grant();
    drain(0, 200, ok);
    exp_bursts++;
    checks++;
    if (rd_pulses != 10) $display("[TB] FAIL timeout_rd_pulses: got %0d, expected 10", rd_pulses);
    else passed++;
    checks++;
    if (!ok || count_mismatch() != 0)
      $display("[TB] FAIL timeout_data: got %0d wrong words (done %0d), expected 0", count_mismatch(), ok);
    else passed++;
  endtask

  task automatic test_backpressure();
    int n;
    bit seen;
    bit ok;
    clear_stats();
    push_words(8);
    wait_req(TMO + 8, n, seen);
    checks++;
    if (!seen || dma_len !== 16'd8) $display("[TB] FAIL bp_len: got %0d (seen %0d), expected 8", dma_len, seen);
    else passed++;
    snapshot(8);
    grant();
    drain(1, 200, ok);
    exp_bursts++;
    checks++;
    if (!ok || got.size() != 8 || count_mismatch() != 0)
      $display("[TB] FAIL bp_data: got %0d words with %0d wrong, expected 8 words", got.size(), count_mismatch());
    else passed++;
    checks++;
    if (viol != 0) $display("[TB] FAIL bp_occupancy: got %0d overfill cycles, expected 0", viol);
    else passed++;
    checks++;
    if (rd_pulses != 8) $display("[TB] FAIL bp_rd_pulses: got %0d, expected 8", rd_pulses);
    else passed++;
  endtask

  task automatic test_random_bursts();
    int n;
    int cnt;
    bit seen;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_stats();
      cnt = $urandom_range(1, 40);
      push_words(cnt);
      wait_req(TMO + 8, n, seen);
      checks++;
      if (!seen || n != TMO + 1 || dma_len !== 16'(cnt))
        $display("[TB] FAIL rand_req: got len %0d after %0d cycles, expected len %0d after %0d", dma_len, n, cnt, TMO + 1);
      else passed++;
      snapshot(cnt);
      grant();
      drain(2, 1000, ok);
      exp_bursts++;
      checks++;
      if (!ok || got.size() != cnt || count_mismatch() != 0 || viol != 0)
        $display("[TB] FAIL rand_data: got %0d words, %0d wrong, %0d overfill, expected %0d words", got.size(), count_mismatch(), viol, cnt);
      else passed++;
      checks++;
      if (burst_cnt !== 32'(exp_bursts)) $display("[TB] FAIL rand_burst_cnt: got %0d, expected %0d", burst_cnt, exp_bursts);
      else passed++;
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int idle_bad = 0;
    bit seen;
    bit ok;
    clear_stats();
    push_words(2 * BURST);
    wait_req(8, n, seen);
    snapshot(BURST);
    grant();
    dma_ready = 1'b1;
    repeat (20) tick();
    enable = 1'b0;
    drain(0, 4 * BURST, ok);
    exp_bursts++;
    checks++;
    if (!ok || got.size() != BURST || count_mismatch() != 0)
      $display("[TB] FAIL endrop_data: got %0d words with %0d wrong, expected %0d", got.size(), count_mismatch(), BURST);
    else passed++;
    repeat (3 * TMO) begin
      tick();
      if (dma_req === 1'b1 || busy === 1'b1) idle_bad++;
    end
    checks++;
    if (idle_bad != 0 || fifo_rd_count != 28'(BURST))
      $display("[TB] FAIL endrop_idle: got %0d active cycles, count %0d, expected 0 and %0d", idle_bad, fifo_rd_count, BURST);
    else passed++;
    enable = 1'b1;
    clear_stats();
    wait_req(8, n, seen);
    checks++;
    if (!seen || n != 1 || dma_len !== 16'(BURST))
      $display("[TB] FAIL endrop_resume: got len %0d after %0d cycles, expected %0d after 1", dma_len, n, BURST);
    else passed++;
    snapshot(BURST);
    grant();
    drain(0, 4 * BURST, ok);
    exp_bursts++;
    checks++;
    if (!ok || count_mismatch() != 0 || burst_cnt !== 32'(exp_bursts))
      $display("[TB] FAIL endrop_second: got %0d wrong, burst_cnt %0d, expected 0 and %0d", count_mismatch(), burst_cnt, exp_bursts);
    else passed++;
  endtask

  // After the first burst, drain() spends one idle cycle, so the flush of
  // the remainder needs TMO more cycles.
  task automatic test_priority();
    int n;
    bit seen;
    bit ok;
    clear_stats();
    push_words(300);
    wait_req(8, n, seen);
    checks++;
    if (!seen || n != 1 || dma_len !== 16'(BURST))
      $display("[TB] FAIL prio_len: got %0d after %0d cycles, expected %0d after 1", dma_len, n, BURST);
    else passed++;
    snapshot(BURST);
    grant();
    drain(2, 8 * BURST, ok);
    exp_bursts++;
    checks++;
    if (!ok || count_mismatch() != 0) $display("[TB] FAIL prio_data: got %0d wrong words, expected 0", count_mismatch());
    else passed++;
    clear_stats();
    wait_req(TMO + 8, n, seen);
    checks++;
    if (!seen || n != TMO || dma_len !== 16'd44)
      $display("[TB] FAIL prio_flush: got len %0d after %0d cycles, expected 44 after %0d", dma_len, n, TMO);
    else passed++;
    snapshot(44);
    grant();
    drain(0, 400, ok);
    exp_bursts++;
    checks++;
    if (!ok || got.size() != 44 || count_mismatch() != 0 || burst_cnt !== 32'(exp_bursts))
      $display("[TB] FAIL prio_flush_data: got %0d words, %0d wrong, burst_cnt %0d, expected 44, 0, %0d", got.size(), count_mismatch(), burst_cnt, exp_bursts);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int rem;
    bit seen;
    bit ok;
    clear_stats();
    push_words(20);
    wait_req(TMO + 8, n, seen);
    grant();
    dma_ready = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dma_req, fifo_rd_en, dma_data_vld, dma_done, busy} !== 5'b0 || dma_data !== 32'd0 || burst_cnt !== 32'd0)
      $display("[TB] FAIL async_reset: got ctrl %b data %0h cnt %0d, expected all 0", {dma_req, fifo_rd_en, dma_data_vld, dma_done, busy}, dma_data, burst_cnt);
    else passed++;
    dma_ready = 1'b0;
    repeat (2) tick();
    outstanding = 0;
    exp_bursts = 0;
    rst_n = 1'b1;
    clear_stats();
    rem = q.size();
    wait_req(TMO + 8, n, seen);
    checks++;
    if (!seen || n != TMO + 1 || dma_len !== 16'(rem))
      $display("[TB] FAIL restart_req: got len %0d after %0d cycles, expected %0d after %0d", dma_len, n, rem, TMO + 1);
    else passed++;
    snapshot(rem);
    grant();
    drain(2, 1000, ok);
    exp_bursts++;
    checks++;
    if (!ok || got.size() != rem || count_mismatch() != 0 || burst_cnt !== 32'(exp_bursts))
      $display("[TB] FAIL restart_data: got %0d words, %0d wrong, burst_cnt %0d, expected %0d, 0, %0d", got.size(), count_mismatch(), burst_cnt, rem, exp_bursts);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_random_bursts();
    test_enable_drop();
    test_priority();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
